// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding and the default operand width live here.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin.
// bo is the borrow out of this bit position.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell.
// start/done handshake; result held until the next done.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             d;
  logic             bo;

  fs_cell u_cell (
    .a   (sa[0]),
    .b   (sb[0]),
    .bin (borrow),
    .d   (d),
    .bo  (bo)
  );

  assign res_nxt = {d, res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (start) nxt = ST_SHIFT;
      ST_SHIFT: if (count == LAST) nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == ST_SHIFT): busy = 1'b1;
      (state == ST_DONE): begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // The last bit is folded straight into diff so it is valid in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            res    <= '0;
            borrow <= 1'b0;
            count  <= '0;
          end
        end
        ST_SHIFT: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          res    <= res_nxt;
          borrow <= bo;
          count  <= count + 1'b1;
          if (count == LAST) begin
            diff <= res_nxt;
            bout <= bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed and random ops on 8-bit and 4-bit
// instances against an arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a(a4), .b(b4), .busy(busy4), .done(done4),
    .diff(diff4), .bout(bout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow iff a < b.
  function automatic logic [31:0] ref_diff(input int x, input int y,
                                           input int w);
    int r;
    r = x - y;
    return 32'(r & ((1 << w) - 1));
  endfunction

  function automatic logic [31:0] ref_bout(input int x, input int y);
    return (x < y) ? 32'd1 : 32'd0;
  endfunction

  // Launch one 8-bit op from IDLE; optionally pulse a stray start at
  // cycle inj. Caller is positioned 1 time unit after a rising edge.
  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     input int inj, input string tag);
    int  n;
    bit  got;
    bit  busy_ok;
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy8), 1);
    n = 0; got = 0; busy_ok = 1;
    for (int i = 1; i <= 30 && !got; i++) begin
      if (inj != 0 && i == inj) begin
        start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
      end else if (inj != 0 && i == inj + 1) begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (done8) begin
        got = 1; n = i;
      end else if (!busy8) begin
        busy_ok = 0;
      end
    end
    start8 = 1'b0;
    chk({tag, "_latency"}, 32'(n), 8);
    chk({tag, "_busy_run"}, 32'(busy_ok), 1);
    chk({tag, "_diff"}, 32'(diff8), ref_diff(x, y, 8));
    chk({tag, "_bout"}, 32'(bout8), ref_bout(x, y));
    chk({tag, "_busy_done"}, 32'(busy8), 1);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, 32'(done8), 0);
    chk({tag, "_idle"}, 32'(busy8), 0);
    chk({tag, "_hold"}, 32'(diff8), ref_diff(x, y, 8));
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y);
    int n;
    a4 = x; b4 = y; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk); #1;
      if (done4) n = i;
    end
    if (n != 4) chk("w4_latency", 32'(n), 4);
    chk("w4_diff", 32'(diff4), ref_diff(x, y, 4));
    chk("w4_bout", 32'(bout4), ref_bout(x, y));
    @(posedge clk); #1;
  endtask

  initial begin
    int q[$];
    int ndone;
    bit stable;
    bit idle;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    #22;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_bout", 32'(bout8), 0);
    chk("rst_busy4", 32'(busy4), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    op8(8'h5A, 8'h3C, 0, "basic");
    op8(8'h00, 8'h01, 0, "borrow");
    op8(8'hFF, 8'hFF, 0, "equal");
    op8(8'h10, 8'h01, 3, "busy_start");

    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    chk("no_second_op", 32'(ndone), 0);

    // Back-to-back with start held high.
    a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
    stable = 1;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk); #1;
      if (done8) q.push_back(c);
      if (q.size() > 0 && diff8 !== 8'h01) stable = 0;
    end
    start8 = 1'b0;
    chk("b2b_count", 32'(q.size() >= 3), 1);
    if (q.size() >= 3) begin
      chk("b2b_gap1", 32'(q[1] - q[0]), 10);
      chk("b2b_gap2", 32'(q[2] - q[1]), 10);
    end
    chk("b2b_stable", 32'(stable), 1);
    chk("b2b_bout", 32'(bout8), 0);
    idle = 0;
    for (int i = 0; i < 15 && !idle; i++) begin
      @(posedge clk); #1;
      if (!busy8 && !done8) idle = 1;
    end
    chk("b2b_drain", 32'(idle), 1);

    // Asynchronous reset mid-operation.
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy8), 0);
    chk("mid_rst_done", 32'(done8), 0);
    chk("mid_rst_diff", 32'(diff8), 0);
    chk("mid_rst_bout", 32'(bout8), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy8), 0);
    op8(8'h03, 8'h05, 0, "post_rst");

    for (int i = 0; i < 20; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      op8(x, y, 0, "rand");
    end

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op4(4'(x), 4'(y));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
